// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame geometry and the sender FSM encoding.
package spi_pkg;

    localparam int FRAME_W = 32;
    localparam int WORD_W  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        LAG   = 3'd3,
        DONE  = 3'd4
    } spi_tx_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period counter for the SPI clock: keeps the sck phase and flags the
// clk cycle at whose end the phase rises or falls. Idles cleared when disabled.
module spi_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic areset,
    input  logic en,
    output logic phase,
    output logic rise,
    output logic fall
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(DIV - 1));
    assign rise = en && wrap && !phase;
    assign fall = en && wrap && phase;

    // Count DIV cycles per half period, toggling the phase on each wrap.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_frame_sender.sv
// SPI master that frames {p1_in, p2_in} MSB first on sck/sdi under load and
// captures the sdo return stream. All pins are registered one cycle behind the
// internal FSM, so the visible frame starts the cycle after start is sampled.
module spi_frame_sender
    import spi_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int LEAD_CYC = 2
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                start,
    input  logic [WORD_W-1:0]   p1_in,
    input  logic [WORD_W-1:0]   p2_in,
    output logic                busy,
    output logic                done,
    output logic [FRAME_W-1:0]  rx_data,
    output logic                sck,
    output logic                sdi,
    input  logic                sdo,
    output logic                load
);

    localparam int LW = (LEAD_CYC > 1) ? $clog2(LEAD_CYC) : 1;

    spi_tx_state_t      state, state_next;
    logic [FRAME_W-1:0] tx, rx;
    logic [4:0]         bit_cnt;
    logic [LW-1:0]      lcnt;
    logic               lead_end, last_fall, accept;
    logic               ph, rise, fall, rise_q;
    logic               load_d, busy_d, done_d, sck_d, sdi_d;

    spi_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .areset (areset),
        .en     (state == SHIFT),
        .phase  (ph),
        .rise   (rise),
        .fall   (fall)
    );

    assign lead_end  = (lcnt == LW'(LEAD_CYC - 1));
    assign last_fall = fall && (bit_cnt == 5'd31);
    // The visible DONE cycle still counts as busy for start purposes.
    assign accept    = (state == IDLE) && start && !done;

    // State register.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = LEAD;
            LEAD:    if (lead_end)  state_next = SHIFT;
            SHIFT:   if (last_fall) state_next = LAG;
            LAG:     if (lead_end)  state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Shift registers and counters.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            tx      <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            lcnt    <= '0;
            rise_q  <= 1'b0;
        end else begin
            rise_q <= rise;
            if (accept)
                tx <= {p1_in, p2_in};
            else if (fall && !last_fall)
                tx <= {tx[FRAME_W-2:0], 1'b0};
            // rise_q marks the edge on which the sck pin goes high.
            if (rise_q)
                rx <= {rx[FRAME_W-2:0], sdo};
            if (state == LEAD || state == LAG)
                lcnt <= lead_end ? '0 : lcnt + LW'(1);
            else
                lcnt <= '0;
            if (state != SHIFT)
                bit_cnt <= '0;
            else if (fall)
                bit_cnt <= bit_cnt + 5'd1;
        end
    end

    // Pin values implied by the current state.
    always_comb begin
        load_d = (state == LEAD) || (state == SHIFT) || (state == LAG);
        busy_d = load_d;
        done_d = (state == DONE);
        sck_d  = ph;
        sdi_d  = load_d ? tx[FRAME_W-1] : 1'b0;
    end

    // Registered pins; rx_data is only refreshed at frame completion.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            load    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= 1'b0;
            sdi     <= 1'b0;
            rx_data <= '0;
        end else begin
            load <= load_d;
            busy <= busy_d;
            done <= done_d;
            sck  <= sck_d;
            sdi  <= sdi_d;
            if (state == DONE)
                rx_data <= rx;
        end
    end

endmodule

// File: tb/tb_spi_frame_sender.sv
// Bench for spi_frame_sender: default, DIV=1/LEAD_CYC=1 and DIV=7 instances.
module tb_spi_frame_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0;
    int nfail = 0;

    // default instance
    logic        areset, start, busy, done, sck, sdi, sdo, load;
    logic [15:0] p1, p2;
    logic [31:0] rx_data;
    logic        loop_mode;
    logic [31:0] ret_word;
    logic [5:0]  ret_idx;

    // remote end: either loopback or a scripted return word, MSB first
    assign sdo = loop_mode ? sdi : (ret_idx[5] ? 1'b0 : ret_word[~ret_idx[4:0]]);

    spi_frame_sender dut0 (
        .clk(clk), .areset(areset), .start(start), .p1_in(p1), .p2_in(p2),
        .busy(busy), .done(done), .rx_data(rx_data), .sck(sck), .sdi(sdi),
        .sdo(sdo), .load(load)
    );

    // corner instances, both in loopback
    logic        start1, busy1, done1, sck1, sdi1, load1;
    logic [15:0] p1b, p2b;
    logic [31:0] rx1;
    spi_frame_sender #(.DIV(1), .LEAD_CYC(1)) dut1 (
        .clk(clk), .areset(areset), .start(start1), .p1_in(p1b), .p2_in(p2b),
        .busy(busy1), .done(done1), .rx_data(rx1), .sck(sck1), .sdi(sdi1),
        .sdo(sdi1), .load(load1)
    );

    logic        start2, busy2, done2, sck2, sdi2, load2;
    logic [31:0] rx2;
    spi_frame_sender #(.DIV(7)) dut2 (
        .clk(clk), .areset(areset), .start(start2), .p1_in(p1b), .p2_in(p2b),
        .busy(busy2), .done(done2), .rx_data(rx2), .sck(sck2), .sdi(sdi2),
        .sdo(sdi2), .load(load2)
    );

    // bus observer for the default instance (runs first on each falling edge)
    logic [31:0] cap;
    int nrise, load_cnt, ndone, done_cyc, bad_sck;
    logic sck_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (sck && !sck_prev) begin
            cap = {cap[30:0], sdi};
            nrise++;
            ret_idx++;
        end
        sck_prev = sck;
        if (load) load_cnt++;
        if (done) begin ndone++; done_cyc = cyc; end
        if (sck && !load) bad_sck++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cap = '0; nrise = 0; load_cnt = 0; ndone = 0; done_cyc = -1; bad_sck = 0; ret_idx = '0;
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    // Send one frame on dut0 and check it against the expected wire behaviour.
    task automatic run_frame(input logic [15:0] a, input logic [15:0] b,
                             input logic lp, input logic [31:0] ret, input bit mid);
        int  k;
        bit  got;
        clear_mon();
        loop_mode = lp; ret_word = ret;
        p1 = a; p2 = b; start = 1'b1;
        k = cyc + 1;
        tick();
        start = 1'b0;
        p1 = 16'($urandom); p2 = 16'($urandom);
        got = 0;
        for (int i = 1; i < 400 && !got; i++) begin
            if (mid && i == 50) start = 1'b1;
            if (mid && i == 51) start = 1'b0;
            tick();
            if (ndone > 0) got = 1;
        end
        start = 1'b0;
        check("done_seen", 64'(got), 64'd1);
        check("done_latency", 64'(done_cyc - k), 64'd261);
        check("load_len", 64'(load_cnt), 64'd260);
        check("sck_rises", 64'(nrise), 64'd32);
        check("sdi_stream", 64'(cap), 64'({a, b}));
        check("rx_data", 64'(rx_data), 64'(lp ? {a, b} : ret));
        check("done_count", 64'(ndone), 64'd1);
        check("sck_outside_frame", 64'(bad_sck), 64'd0);
    endtask

    initial begin
        int k1, d1, r1, r2, prev2;
        bit got;
        int idle_bad;
        logic [31:0] w;

        areset = 1'b0; start = 1'b0; start1 = 1'b0; start2 = 1'b0;
        p1 = '0; p2 = '0; p1b = '0; p2b = '0;
        loop_mode = 1'b0; ret_word = '0;
        clear_mon();

        // reset and idle
        repeat (5) tick();
        check("reset_outputs", 64'({sck, sdi, load, busy, done, rx_data}), 64'd0);
        areset = 1'b1;
        idle_bad = 0;
        repeat (100) begin
            tick();
            if ({sck, load, busy, done} !== 4'b0 || rx_data !== 32'd0) idle_bad++;
        end
        check("idle_quiet", 64'(idle_bad), 64'd0);

        // directed frames
        run_frame(16'h0ABC, 16'h0123, 1'b0, $urandom, 1'b0);
        tick();
        run_frame(16'hFFFF, 16'h0000, 1'b1, 32'd0, 1'b0);
        tick();
        run_frame(16'hA5A5, 16'h5A5A, 1'b1, 32'd0, 1'b0);

        // randomized frames with a random return stream
        repeat (3) begin
            tick();
            w = $urandom;
            run_frame(w[31:16], w[15:0], 1'b0, $urandom, 1'b0);
        end

        // start while busy is ignored; a start one cycle after done is taken
        tick();
        run_frame(16'h1357, 16'h2468, 1'b1, 32'd0, 1'b1);
        tick();
        w = $urandom;
        run_frame(w[31:16], w[15:0], 1'b1, 32'd0, 1'b0);

        // start during the done cycle is ignored
        clear_mon();
        p1 = 16'hDEAD; p2 = 16'hBEEF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("start_in_done_ignored", 64'({load_cnt, ndone}), 64'd0);

        // reset at bit 10 aborts immediately
        clear_mon();
        loop_mode = 1'b1;
        p1 = 16'h3C3C; p2 = 16'hC3C3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 300 && nrise < 10; i++) tick();
        check("reach_bit10", 64'(nrise), 64'd10);
        @(posedge clk); #2;
        areset = 1'b0;
        #1;
        check("async_abort", 64'({sck, load, busy}), 64'd0);
        repeat (3) tick();
        areset = 1'b1;
        repeat (3) tick();
        check("no_done_on_abort", 64'(ndone), 64'd0);
        w = $urandom;
        run_frame(w[31:16], w[15:0], 1'b1, 32'd0, 1'b0);

        // DIV=1, LEAD_CYC=1
        w = $urandom;
        p1b = w[31:16]; p2b = w[15:0]; start1 = 1'b1;
        k1 = cyc + 1;
        tick();
        start1 = 1'b0;
        got = 0; d1 = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (done1) begin got = 1; d1 = cyc; end
        end
        check("div1_latency", 64'(d1 - k1), 64'd67);
        check("div1_rx", 64'(rx1), 64'(w));

        // DIV=7: sck period and data
        w = $urandom;
        p1b = w[31:16]; p2b = w[15:0]; start2 = 1'b1;
        k1 = cyc + 1;
        tick();
        start2 = 1'b0;
        got = 0; d1 = -1; r1 = -1; r2 = -1; prev2 = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            tick();
            if (sck2 && !prev2) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            prev2 = int'(sck2);
            if (done2) begin got = 1; d1 = cyc; end
        end
        check("div7_sck_period", 64'(r2 - r1), 64'd14);
        check("div7_latency", 64'(d1 - k1), 64'd453);
        check("div7_rx", 64'(rx2), 64'(w));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
